lg_gate_response_checker: RTL and testbench



---
 rtl/lg_gate_response_checker.sv | 170 +++++++++++++++++
 tb/tb_lg_gate_response_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lg_gate_response_checker.sv
// Sequential stimulus/response checker for a quad-function gate part (Y1=~A, Y2=A, Y3=A^B, Y4=~(A^B)).
// Optional macro LG_CHECK_SYNC_EN adds a 2-flop synchronizer on Y1..Y4 and stretches each settle window by 2 cycles.
module lg_gate_response_checker #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned VEC_COUNT     = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_y1,
    input  logic       i_y2,
    input  logic       i_y3,
    input  logic       i_y4,
    output logic       o_a,
    output logic       o_b,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_fail_mask,
    output logic [1:0] o_fail_vec,
    output logic [2:0] o_fail_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Truth table of the gate family, ordered {Y4,Y3,Y2,Y1}.
    function automatic logic [3:0] expected_y(input logic a, input logic b);
        expected_y = {~(a ^ b), a ^ b, a, ~a};
    endfunction

    logic [3:0] w_y;

`ifdef LG_CHECK_SYNC_EN
    localparam int unsigned SETTLE_TOTAL = SETTLE_CYCLES + 2;
    localparam int unsigned CNT_W        = 9;

    logic [3:0] r_y_meta;
    logic [3:0] r_y_sync;

    // Two-flop synchronizer for responses coming from an asynchronous board.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_y_meta <= 4'b0000;
            r_y_sync <= 4'b0000;
        end else begin
            r_y_meta <= {i_y4, i_y3, i_y2, i_y1};
            r_y_sync <= r_y_meta;
        end
    end

    assign w_y = r_y_sync;
`else
    localparam int unsigned SETTLE_TOTAL = SETTLE_CYCLES;
    localparam int unsigned CNT_W        = 8;

    assign w_y = {i_y4, i_y3, i_y2, i_y1};
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_TOTAL - 1);
    localparam logic [1:0]       IDX_LAST = 2'(VEC_COUNT - 1);

    state_t           r_state;
    logic [1:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_a;
    logic             r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [3:0]       r_fail_mask;
    logic [1:0]       r_fail_vec;
    logic [2:0]       r_fail_cnt;

    logic [3:0]       w_mismatch;
    logic             w_any_fail;
    logic [2:0]       w_fail_cnt_next;

    // Compare the sampled response against the vector currently held on A/B.
    always_comb begin
        w_mismatch      = w_y ^ expected_y(r_a, r_b);
        w_any_fail      = |w_mismatch;
        if (w_any_fail) begin
            w_fail_cnt_next = r_fail_cnt + 3'd1;
        end else begin
            w_fail_cnt_next = r_fail_cnt;
        end
    end

    // Run sequencer: APPLY -> SETTLE x N -> SAMPLE per vector, results registered as they accrue.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_idx       <= 2'd0;
            r_cnt       <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= 4'b0000;
            r_fail_vec  <= 2'd0;
            r_fail_cnt  <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state     <= S_APPLY;
                        r_idx       <= 2'd0;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_fail_mask <= 4'b0000;
                        r_fail_vec  <= 2'd0;
                        r_fail_cnt  <= 3'd0;
                    end
                end
                S_APPLY: begin
                    r_a     <= r_idx[1];
                    r_b     <= r_idx[0];
                    r_cnt   <= '0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    r_fail_mask <= r_fail_mask | w_mismatch;
                    r_fail_cnt  <= w_fail_cnt_next;
                    if (w_any_fail && (r_fail_cnt == 3'd0)) begin
                        r_fail_vec <= {r_a, r_b};
                    end
                    if (r_idx == IDX_LAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_fail_cnt_next == 3'd0);
                    end else begin
                        r_idx   <= r_idx + 2'd1;
                        r_state <= S_APPLY;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_a         = r_a;
    assign o_b         = r_b;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_fail_mask = r_fail_mask;
    assign o_fail_vec  = r_fail_vec;
    assign o_fail_cnt  = r_fail_cnt;

endmodule

// File: tb/tb_lg_gate_response_checker.sv
// Scoreboard bench for lg_gate_response_checker: a gate model with injectable faults drives Y1..Y4,
// expected run results are queued at START and checked by an independent monitor when DONE rises.
module tb_lg_gate_response_checker;

`ifdef LG_CHECK_SYNC_EN
    localparam int LAT = 32;
`else
    localparam int LAT = 24;
`endif

    localparam int FM_IDEAL  = 0;
    localparam int FM_Y3_SA0 = 1;
    localparam int FM_SWAP   = 2;
    localparam int FM_GLITCH = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       y1, y2, y3, y4;
    logic       a, b, busy, done, pass;
    logic [3:0] fail_mask;
    logic [1:0] fail_vec;
    logic [2:0] fail_cnt;

    int fault_mode = FM_IDEAL;
    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    logic [1:0] prev_ab = 2'b00;
    int         gcnt = 15;

    typedef struct {
        logic       pass;
        logic [3:0] mask;
        logic [1:0] vec;
        logic [2:0] cnt;
        int         acc;
    } exp_t;

    exp_t q[$];

    lg_gate_response_checker dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_y1(y1), .i_y2(y2), .i_y3(y3), .i_y4(y4),
        .o_a(a), .o_b(b), .o_busy(busy), .o_done(done), .o_pass(pass),
        .o_fail_mask(fail_mask), .o_fail_vec(fail_vec), .o_fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cycles since A/B last changed; drives the short Y1 glitch right after each new vector.
    always @(negedge clk) begin
        if ({a, b} != prev_ab) begin
            prev_ab <= {a, b};
            gcnt    <= 0;
        end else if (gcnt < 15) begin
            gcnt <= gcnt + 1;
        end
    end

    // Gate model with fault injection.
    always_comb begin
        y1 = ~a;
        y2 = a;
        y3 = a ^ b;
        y4 = ~(a ^ b);
        case (fault_mode)
            FM_Y3_SA0: y3 = 1'b0;
            FM_SWAP: begin
                y3 = ~(a ^ b);
                y4 = a ^ b;
            end
            FM_GLITCH: if (gcnt < 2) y1 = a;
            default: y1 = ~a;
        endcase
    end

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic start_run(input logic push, input logic ep, input logic [3:0] em,
                             input logic [1:0] ev, input logic [2:0] ec);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.pass = ep; e.mask = em; e.vec = ev; e.cnt = ec; e.acc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ab"}, int'({a, b}), 0);
        chk({nm, "_busy_done_pass"}, int'({busy, done, pass}), 0);
        chk({nm, "_mask"}, int'(fail_mask), 0);
        chk({nm, "_vec_cnt"}, int'({fail_vec, fail_cnt}), 0);
    endtask

    // Monitor: logs the A/B sequence of each run and checks results against the queue when DONE rises.
    initial begin
        logic       prev_done = 1'b0;
        logic       prev_busy = 1'b0;
        logic [7:0] ab_log = 8'h00;
        logic [2:0] last = 3'b100;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                ab_log = 8'h00;
                last   = 3'b100;
            end
            if (busy && ({1'b0, a, b} != last)) begin
                ab_log = {ab_log[5:0], a, b};
                last   = {1'b0, a, b};
            end
            if (done && !prev_done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc - e.acc, LAT);
                    chk("pass", int'(pass), int'(e.pass));
                    chk("fail_mask", int'(fail_mask), int'(e.mask));
                    chk("fail_vec", int'(fail_vec), int'(e.vec));
                    chk("fail_cnt", int'(fail_cnt), int'(e.cnt));
                    chk("busy_at_done", int'(busy), 0);
                    chk("ab_hold_11", int'({a, b}), 3);
                    chk("ab_sequence", int'(ab_log), 8'h1B);
                end
            end
            prev_done = done;
            prev_busy = busy;
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        fault_mode = FM_IDEAL;
        start_run(1'b1, 1'b1, 4'b0000, 2'd0, 3'd0);
        wait_done();

        fault_mode = FM_Y3_SA0;
        start_run(1'b1, 1'b0, 4'b0100, 2'b01, 3'd2);
        wait_done();

        fault_mode = FM_SWAP;
        start_run(1'b1, 1'b0, 4'b1100, 2'b00, 3'd4);
        wait_done();

        // START in DONE clears the previous failing results immediately.
        fault_mode = FM_IDEAL;
        start_run(1'b1, 1'b1, 4'b0000, 2'd0, 3'd0);
        chk("restart_busy_done", int'({busy, done}), 2);
        chk("restart_mask", int'(fail_mask), 0);
        chk("restart_vec_cnt_pass", int'({fail_vec, fail_cnt, pass}), 0);
        wait_done();

        // START pulses during a run at cycles 5 and 15 are ignored.
        start_run(1'b1, 1'b1, 4'b0000, 2'd0, 3'd0);
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();

        // Reset in the middle of a run aborts it asynchronously.
        start_run(1'b0, 1'b0, 4'b0000, 2'd0, 3'd0);
        fault_mode = FM_SWAP;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        fault_mode = FM_IDEAL;
        start_run(1'b1, 1'b1, 4'b0000, 2'd0, 3'd0);
        wait_done();

        // Y1 glitch confined to the early settle cycles must not be seen.
        fault_mode = FM_GLITCH;
        start_run(1'b1, 1'b1, 4'b0000, 2'd0, 3'd0);
        wait_done();

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
